// File: rtl/roi_readout_sequencer_if.sv
// Exposure-controller handshake and readout timing bus of the ROI readout sequencer.
interface roi_readout_sequencer_if #(
    parameter int unsigned ROW_W = 8,
    parameter int unsigned MUX_W = 6
);
    logic             START;
    logic             ABORT;
    logic [1:0]       MODE;
    logic [ROW_W-1:0] ROW_FIRST;
    logic [ROW_W-1:0] ROW_LAST;
    logic             PIX_CE;
    logic             PHI1;
    logic             PRECH_COL;
    logic             PIXRES;
    logic             PRECHN_AMP;
    logic [ROW_W-1:0] ROW_ADD;
    logic [MUX_W-1:0] MUX_ADD;
    logic             ADC_DATA_VALID;
    logic             BUSY;
    logic             DONE;
    logic             CFG_ERR;
    logic [15:0]      FRAME_CNT;

    // Exposure controller side
    modport master (
        output START, ABORT, MODE, ROW_FIRST, ROW_LAST,
        input  PIX_CE, PHI1, PRECH_COL, PIXRES, PRECHN_AMP, ROW_ADD, MUX_ADD,
               ADC_DATA_VALID, BUSY, DONE, CFG_ERR, FRAME_CNT
    );

    // Sequencer side
    modport slave (
        input  START, ABORT, MODE, ROW_FIRST, ROW_LAST,
        output PIX_CE, PHI1, PRECH_COL, PIXRES, PRECHN_AMP, ROW_ADD, MUX_ADD,
               ADC_DATA_VALID, BUSY, DONE, CFG_ERR, FRAME_CNT
    );
endinterface

// File: rtl/roi_readout_sequencer.sv
// Readout timing generator for the ToF imager: pixel-period enable, row phase
// sequencing (PHI1/PRECH_COL, PIXRES, output mux) over a programmable row window,
// and the ADC data-valid latency line, all on ADC_CLK.
module roi_readout_sequencer #(
    parameter int unsigned NUM_ROWS  = 160,
    parameter int unsigned NUM_MUX   = 46,
    parameter int unsigned ROW_W     = 8,
    parameter int unsigned MUX_W     = 6,
    parameter int unsigned PIX_DIV   = 3,
    parameter int unsigned PHI1_CNT  = 9,
    parameter int unsigned PRECH_CNT = 1,
    parameter int unsigned PHI2_CNT  = 9,
    parameter int unsigned ADC_LAT   = 24
) (
    input  logic                    ADC_CLK,
    input  logic                    RESET,
    roi_readout_sequencer_if.slave  bus
);

    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned CNT_MAX = (PHI1_CNT > PHI2_CNT) ? PHI1_CNT : PHI2_CNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2,
        ST_MUX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_nxt;
    logic               pix_ce_q;
    logic               start_pend_q, start_pend_d;
    logic               abort_pend_q, abort_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   last_q, last_d;
    logic               repeat_q, repeat_d;
    logic [MUX_W-1:0]   mux_q, mux_d;
    logic               phi1_q, phi1_d;
    logic               prech_q, prech_d;
    logic               pixres_q, pixres_d;
    logic               amp_q, amp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [15:0]        frame_q, frame_d;
    logic [ADC_LAT-1:0] lat_q;
    logic [ROW_W-1:0]   win_first, win_last;
    logic               win_ok;

    // Pixel-period divider; PIX_CE is high for the cycle where the divider sits at its top
    assign div_nxt = (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            div_q    <= div_nxt;
            pix_ce_q <= (div_nxt == DIV_W'(PIX_DIV - 1));
        end
    end

    // ADC conversion latency line; drains on abort, cleared only by reset
    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            lat_q <= '0;
        end else begin
            lat_q <= ADC_LAT'({lat_q, amp_q});
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            start_pend_q <= 1'b0;
            abort_pend_q <= 1'b0;
            cnt_q        <= '0;
            row_q        <= '0;
            last_q       <= '0;
            repeat_q     <= 1'b0;
            mux_q        <= '0;
            phi1_q       <= 1'b0;
            prech_q      <= 1'b0;
            pixres_q     <= 1'b0;
            amp_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            abort_pend_q <= abort_pend_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            last_q       <= last_d;
            repeat_q     <= repeat_d;
            mux_q        <= mux_d;
            phi1_q       <= phi1_d;
            prech_q      <= prech_d;
            pixres_q     <= pixres_d;
            amp_q        <= amp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            frame_q      <= frame_d;
        end
    end

    // Next-state: handshake latching, window check, and row phase sequencing on pixel ticks
    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q | (bus.START & ~busy_q);
        abort_pend_d = abort_pend_q | (bus.ABORT & busy_q);
        cnt_d        = cnt_q;
        row_d        = row_q;
        last_d       = last_q;
        repeat_d     = repeat_q;
        mux_d        = mux_q;
        phi1_d       = phi1_q;
        prech_d      = prech_q;
        pixres_d     = pixres_q;
        amp_d        = amp_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        frame_d      = frame_q;
        win_first    = '0;
        win_last     = '0;
        win_ok       = 1'b0;

        case (bus.MODE)
            2'd0: begin
                win_last = ROW_W'(NUM_ROWS - 1);
                win_ok   = 1'b1;
            end
            2'd1: begin
                win_first = bus.ROW_FIRST;
                win_last  = bus.ROW_LAST;
                win_ok    = (bus.ROW_FIRST <= bus.ROW_LAST) && (32'(bus.ROW_LAST) < NUM_ROWS);
            end
            2'd2: begin
                win_first = bus.ROW_FIRST;
                win_last  = bus.ROW_FIRST;
                win_ok    = (32'(bus.ROW_FIRST) < NUM_ROWS);
            end
            default: begin
                win_ok = 1'b0;
            end
        endcase

        if (pix_ce_q) begin
            if (abort_pend_q) begin
                // Abort beats everything, including a pending start and a normal row end
                state_d      = ST_IDLE;
                start_pend_d = 1'b0;
                abort_pend_d = 1'b0;
                cnt_d        = '0;
                phi1_d       = 1'b0;
                prech_d      = 1'b0;
                pixres_d     = 1'b0;
                amp_d        = 1'b0;
                busy_d       = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_pend_q) begin
                            start_pend_d = 1'b0;
                            if (win_ok) begin
                                state_d  = ST_PH1;
                                row_d    = win_first;
                                last_d   = win_last;
                                repeat_d = (bus.MODE == 2'd2);
                                cnt_d    = '0;
                                phi1_d   = 1'b1;
                                prech_d  = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                cfg_err_d = 1'b1;
                            end
                        end
                    end
                    ST_PH1: begin
                        if (cnt_q == CNT_W'(PHI1_CNT - 1)) begin
                            state_d  = ST_PH2;
                            cnt_d    = '0;
                            phi1_d   = 1'b0;
                            prech_d  = 1'b0;
                            pixres_d = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            prech_d = (32'(cnt_q) + 32'd1 < PRECH_CNT);
                        end
                    end
                    ST_PH2: begin
                        if (cnt_q == CNT_W'(PHI2_CNT - 1)) begin
                            state_d  = ST_MUX;
                            cnt_d    = '0;
                            pixres_d = 1'b0;
                            amp_d    = 1'b1;
                            mux_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_MUX: begin
                        if (mux_q == MUX_W'(NUM_MUX - 1)) begin
                            amp_d = 1'b0;
                            if (repeat_q || (row_q != last_q)) begin
                                // Next row (or the same row again in repeat mode)
                                state_d = ST_PH1;
                                phi1_d  = 1'b1;
                                prech_d = 1'b1;
                                if (repeat_q) begin
                                    frame_d = frame_q + 16'd1;
                                end else begin
                                    row_d = row_q + ROW_W'(1);
                                end
                            end else begin
                                state_d = ST_IDLE;
                                frame_d = frame_q + 16'd1;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            mux_d = mux_q + MUX_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.PIX_CE         = pix_ce_q;
    assign bus.PHI1           = phi1_q;
    assign bus.PRECH_COL      = prech_q;
    assign bus.PIXRES         = pixres_q;
    assign bus.PRECHN_AMP     = amp_q;
    assign bus.ROW_ADD        = row_q;
    assign bus.MUX_ADD        = mux_q;
    assign bus.ADC_DATA_VALID = lat_q[ADC_LAT-1];
    assign bus.BUSY           = busy_q;
    assign bus.DONE           = done_q;
    assign bus.CFG_ERR        = cfg_err_q;
    assign bus.FRAME_CNT      = frame_q;

endmodule

// File: tb/tb_roi_readout_sequencer.sv
// Self-checking bench for roi_readout_sequencer: randomized windows, rejects,
// repeat/abort and mid-run reset against a tick-arithmetic reference model.
module tb_roi_readout_sequencer;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_MUX   = 3;
    localparam int ROW_W     = 3;
    localparam int MUX_W     = 2;
    localparam int PIX_DIV   = 3;
    localparam int PHI1_CNT  = 2;
    localparam int PRECH_CNT = 1;
    localparam int PHI2_CNT  = 2;
    localparam int ADC_LAT   = 5;
    localparam int ROW_T     = PHI1_CNT + PHI2_CNT + NUM_MUX;
    localparam int ROW_CYC   = ROW_T * PIX_DIV;

    typedef logic [29:0] vec_t;

    typedef struct {
        bit busy;
        bit phi1;
        bit prech;
        bit pixres;
        bit amp;
        bit done;
        int row;
        int mux;
        int frames;
    } exp_t;

    logic ADC_CLK = 1'b0;
    logic RESET   = 1'b1;
    int   ecnt    = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   row_hold = 0;
    int   mux_hold = 0;
    int   frame_base = 0;

    roi_readout_sequencer_if #(.ROW_W(ROW_W), .MUX_W(MUX_W)) bus ();

    roi_readout_sequencer #(
        .NUM_ROWS(NUM_ROWS), .NUM_MUX(NUM_MUX), .ROW_W(ROW_W), .MUX_W(MUX_W),
        .PIX_DIV(PIX_DIV), .PHI1_CNT(PHI1_CNT), .PRECH_CNT(PRECH_CNT),
        .PHI2_CNT(PHI2_CNT), .ADC_LAT(ADC_LAT)
    ) dut (
        .ADC_CLK(ADC_CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    // Edges since reset release; pixel ticks fall on multiples of PIX_DIV
    always @(posedge ADC_CLK) begin
        if (RESET) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    // Expected outputs j cycles after the accepting tick edge (j<0: not yet started)
    function automatic exp_t model(int j, int first, int nrows, bit rep, int rh, int mh);
        exp_t e;
        int tick, r, pos;
        e.busy = 0; e.phi1 = 0; e.prech = 0; e.pixres = 0; e.amp = 0; e.done = 0;
        e.row = rh; e.mux = mh; e.frames = 0;
        if (j < 0) return e;
        if (!rep && j >= nrows * ROW_CYC) begin
            e.done   = (j == nrows * ROW_CYC);
            e.row    = first + nrows - 1;
            e.mux    = NUM_MUX - 1;
            e.frames = 1;
            return e;
        end
        tick = j / PIX_DIV;
        r    = tick / ROW_T;
        pos  = tick % ROW_T;
        e.busy   = 1;
        e.phi1   = (pos < PHI1_CNT);
        e.prech  = (pos < PRECH_CNT);
        e.pixres = (pos >= PHI1_CNT) && (pos < PHI1_CNT + PHI2_CNT);
        e.amp    = (pos >= PHI1_CNT + PHI2_CNT);
        if (e.amp)       e.mux = pos - PHI1_CNT - PHI2_CNT;
        else if (r > 0)  e.mux = NUM_MUX - 1;
        e.row    = rep ? first : first + r;
        e.frames = rep ? r : 0;
        return e;
    endfunction

    function automatic vec_t obs();
        return {bus.PIX_CE, bus.ADC_DATA_VALID, bus.BUSY, bus.PHI1, bus.PRECH_COL,
                bus.PIXRES, bus.PRECHN_AMP, bus.DONE, bus.CFG_ERR,
                bus.ROW_ADD, bus.MUX_ADD, bus.FRAME_CNT};
    endfunction

    function automatic vec_t pack(exp_t e, bit v, bit cfg);
        bit pce;
        pce = ((ecnt % PIX_DIV) == PIX_DIV - 1);
        return {pce, v, e.busy, e.phi1, e.prech, e.pixres, e.amp, e.done, cfg,
                ROW_W'(e.row), MUX_W'(e.mux), 16'(frame_base + e.frames)};
    endfunction

    function automatic int accept_edge(int e);
        return ((e + 2 + PIX_DIV - 1) / PIX_DIV) * PIX_DIV;
    endfunction

    task automatic test_reset();
        vec_t act, exp;
        RESET = 1'b1;
        bus.START = 1'b1;
        bus.MODE = 2'd0;
        repeat (4) @(negedge ADC_CLK);
        act = obs();
        exp = '0;
        n_checks++;
        if (act !== exp) $display("FAIL reset_outputs got=%h exp=%h", act, exp);
        else n_pass++;
        bus.START = 1'b0;
        RESET = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ADC_CLK);
            act = obs();
            exp = pack(model(-1, 0, 0, 0, row_hold, mux_hold), 1'b0, 1'b0);
            n_checks++;
            if (act !== exp) $display("FAIL reset_idle i=%0d got=%h exp=%h", i, act, exp);
            else n_pass++;
        end
    endtask

    task automatic test_window(int mode, int rf, int rl);
        int first, nrows, e, n, j, run, start_again;
        vec_t act, exp;
        exp_t ex, ev;
        first = (mode == 0) ? 0 : rf;
        nrows = (mode == 0) ? NUM_ROWS : rl - rf + 1;
        run   = nrows * ROW_CYC;
        start_again = $urandom_range(PIX_DIV, run - 2 * PIX_DIV);
        repeat ($urandom_range(0, 4)) @(negedge ADC_CLK);
        bus.MODE      = 2'(mode);
        bus.ROW_FIRST = ROW_W'(rf);
        bus.ROW_LAST  = ROW_W'(rl);
        bus.START     = 1'b1;
        e = ecnt;
        n = accept_edge(e);
        for (int k = 0; k < n - e + run + ADC_LAT + 2 * PIX_DIV; k++) begin
            @(negedge ADC_CLK);
            j = ecnt - n;
            act = obs();
            ex = model(j, first, nrows, 1'b0, row_hold, mux_hold);
            ev = model(j - ADC_LAT, first, nrows, 1'b0, row_hold, mux_hold);
            exp = pack(ex, ev.amp, 1'b0);
            n_checks++;
            if (act !== exp) $display("FAIL window mode=%0d j=%0d got=%h exp=%h", mode, j, act, exp);
            else n_pass++;
            // A second START while busy must be dropped; config changes after acceptance are ignored
            bus.START = (j == start_again);
            if (j == 1) begin
                bus.MODE      = 2'd3;
                bus.ROW_FIRST = ROW_W'($urandom);
                bus.ROW_LAST  = ROW_W'($urandom);
            end
        end
        bus.START = 1'b0;
        frame_base += 1;
        row_hold = first + nrows - 1;
        mux_hold = NUM_MUX - 1;
    endtask

    task automatic test_cfg_err();
        int modes[4];
        int firsts[4];
        int lasts[4];
        int e, n, j;
        vec_t act, exp;
        modes[0] = 3; firsts[0] = 0; lasts[0] = 0;
        modes[1] = 1; firsts[1] = 3; lasts[1] = 1;
        modes[2] = 1; firsts[2] = $urandom_range(0, NUM_ROWS - 1); lasts[2] = $urandom_range(NUM_ROWS, 7);
        modes[3] = 2; firsts[3] = $urandom_range(NUM_ROWS, 7); lasts[3] = 0;
        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge ADC_CLK);
            bus.MODE      = 2'(modes[t]);
            bus.ROW_FIRST = ROW_W'(firsts[t]);
            bus.ROW_LAST  = ROW_W'(lasts[t]);
            bus.START     = 1'b1;
            e = ecnt;
            n = accept_edge(e);
            for (int k = 0; k < n - e + 3 * PIX_DIV; k++) begin
                @(negedge ADC_CLK);
                bus.START = 1'b0;
                j = ecnt - n;
                act = obs();
                exp = pack(model(-1, 0, 0, 0, row_hold, mux_hold), 1'b0, (j == 0));
                n_checks++;
                if (act !== exp) $display("FAIL cfg_err case=%0d j=%0d got=%h exp=%h", t, j, act, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_repeat_abort();
        int r, e, n, j, ja, m, jj;
        bit v;
        vec_t act, exp;
        exp_t ex, em;
        r = $urandom_range(0, NUM_ROWS - 1);
        ja = 3 * ROW_CYC + $urandom_range(0, ROW_CYC - 7);
        m  = ((ja + 2 + PIX_DIV - 1) / PIX_DIV) * PIX_DIV;
        em = model(m - 1, r, 1, 1'b1, row_hold, mux_hold);
        bus.MODE      = 2'd2;
        bus.ROW_FIRST = ROW_W'(r);
        bus.ROW_LAST  = ROW_W'($urandom);
        bus.START     = 1'b1;
        e = ecnt;
        n = accept_edge(e);
        for (int k = 0; k < n - e + m + ADC_LAT + 3 * PIX_DIV; k++) begin
            @(negedge ADC_CLK);
            j = ecnt - n;
            bus.START = 1'b0;
            act = obs();
            if (j < m) begin
                ex = model(j, r, 1, 1'b1, row_hold, mux_hold);
            end else begin
                ex = em;
                ex.busy = 0; ex.phi1 = 0; ex.prech = 0; ex.pixres = 0; ex.amp = 0; ex.done = 0;
            end
            jj = j - ADC_LAT;
            v = 1'b0;
            if (jj < m) v = model(jj, r, 1, 1'b1, row_hold, mux_hold).amp;
            exp = pack(ex, v, 1'b0);
            n_checks++;
            if (act !== exp) $display("FAIL repeat_abort j=%0d got=%h exp=%h", j, act, exp);
            else n_pass++;
            bus.ABORT = (j == ja);
        end
        bus.ABORT = 1'b0;
        frame_base += em.frames;
        row_hold = r;
        mux_hold = em.mux;
    endtask

    task automatic test_reset_mid_run();
        int e, n, j, jr;
        vec_t act, exp;
        exp_t ex, ev;
        jr = PIX_DIV * (PHI1_CNT + PHI2_CNT) + $urandom_range(0, ADC_LAT - 2);
        bus.MODE  = 2'd0;
        bus.START = 1'b1;
        e = ecnt;
        n = accept_edge(e);
        for (int k = 0; k <= n - e + jr; k++) begin
            @(negedge ADC_CLK);
            bus.START = 1'b0;
            j = ecnt - n;
            act = obs();
            ex = model(j, 0, NUM_ROWS, 1'b0, row_hold, mux_hold);
            ev = model(j - ADC_LAT, 0, NUM_ROWS, 1'b0, row_hold, mux_hold);
            exp = pack(ex, ev.amp, 1'b0);
            n_checks++;
            if (act !== exp) $display("FAIL pre_reset j=%0d got=%h exp=%h", j, act, exp);
            else n_pass++;
        end
        RESET = 1'b1;
        frame_base = 0;
        row_hold = 0;
        mux_hold = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge ADC_CLK);
            if (k == 2) RESET = 1'b0;
            act = obs();
            exp = pack(model(-1, 0, 0, 0, 0, 0), 1'b0, 1'b0);
            n_checks++;
            if (act !== exp) $display("FAIL reset_mid_run k=%0d got=%h exp=%h", k, act, exp);
            else n_pass++;
        end
    endtask

    initial begin
        int rf, rl;
        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.MODE      = 2'd0;
        bus.ROW_FIRST = '0;
        bus.ROW_LAST  = '0;
        test_reset();
        test_window(0, 0, 0);
        test_window(1, 1, 2);
        for (int i = 0; i < 3; i++) begin
            rf = $urandom_range(0, NUM_ROWS - 1);
            rl = $urandom_range(rf, NUM_ROWS - 1);
            test_window(1, rf, rl);
        end
        test_cfg_err();
        test_repeat_abort();
        test_window(1, 0, 0);
        test_reset_mid_run();
        test_window(0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1);
    end

endmodule
